// File: rtl/vrf_mp_xor.sv
// Multi-ported register file built from XOR-replicated banks: one bank per write port,
// with a CLEAR/READY sequencer that zeroes the whole array after reset or on request.
//
// state   | meaning
// S_CLEAR | sweeping one address per cycle to zero, accesses ignored, ready_o=0
// S_READY | array initialised, reads and writes accepted, ready_o=1
module vrf_mp_xor #(
    parameter int R_PORTS_NUM  = 8,
    parameter int W_PORTS_NUM  = 4,
    parameter int MEM_DEPTH    = 1024,
    parameter int MEM_WIDTH    = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                                              clk,
    input  logic                                              rstn,
    input  logic                                              clear_i,
    output logic                                              ready_o,
    input  logic [R_PORTS_NUM-1:0][$clog2(MEM_DEPTH)-1:0]     raddr_i,
    input  logic [R_PORTS_NUM-1:0]                            ren_i,
    output logic [R_PORTS_NUM-1:0][MEM_WIDTH-1:0]             dout_o,
    output logic [R_PORTS_NUM-1:0]                            dvalid_o,
    input  logic [W_PORTS_NUM-1:0][$clog2(MEM_DEPTH)-1:0]     waddr_i,
    input  logic [W_PORTS_NUM-1:0][MEM_WIDTH/8-1:0]           bwe_i,
    input  logic [W_PORTS_NUM-1:0]                            wen_i,
    input  logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0]             din_i,
    output logic [W_PORTS_NUM-1:0]                            conflict_o
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int NB = MEM_WIDTH / 8;
    localparam int NL = W_PORTS_NUM - 1;
    localparam int RP = R_PORTS_NUM;
    localparam int WP = W_PORTS_NUM;
    localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    function automatic logic [MEM_WIDTH-1:0] f_merge(
        input logic [MEM_WIDTH-1:0] old_word,
        input logic [NB-1:0]        en,
        input logic [MEM_WIDTH-1:0] new_word
    );
        logic [MEM_WIDTH-1:0] res;
        res = old_word;
        for (int k = 0; k < NB; k++) begin
            if (en[k]) begin
                res[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return res;
    endfunction

    state_t                       r_state, w_state_nxt;
    logic [AW-1:0]                r_clr_addr, w_clr_addr_nxt;
    logic                         w_accept;
    logic                         w_clr_we;

    logic [WP-1:0]                w_wacc;
    logic [WP-1:0][NB-1:0]        w_lost;
    logic [WP-1:0][NB-1:0]        w_eff_bwe;
    logic [WP-1:0]                w_conf;
    logic [WP-1:0][MEM_WIDTH-1:0] w_other;

    logic [WP-1:0]                r_s2_valid;
    logic [WP-1:0][AW-1:0]        r_s2_addr;
    logic [WP-1:0][NB-1:0]        r_s2_bwe;
    logic [WP-1:0][MEM_WIDTH-1:0] r_s2_din;
    logic [WP-1:0][MEM_WIDTH-1:0] r_s2_other;
    logic [WP-1:0]                r_conflict;
    logic [WP-1:0]                w_s2_we;
    logic [WP-1:0][MEM_WIDTH-1:0] w_s2_wdata;

    logic [RP-1:0]                w_racc;
    logic [RP-1:0][MEM_WIDTH-1:0] w_rdata;
    logic [RP-1:0]                r_rv1;
    logic [RP-1:0][MEM_WIDTH-1:0] r_rd1;

    logic [MEM_WIDTH-1:0]         w_wpart [WP][WP];
    logic [MEM_WIDTH-1:0]         w_rpart [RP][WP];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_addr <= w_clr_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_clr_addr_nxt = r_clr_addr;
        case (r_state)
            S_CLEAR: begin
                if (clear_i) begin
                    w_clr_addr_nxt = '0;
                end else if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt    = S_READY;
                    w_clr_addr_nxt = '0;
                end else begin
                    w_clr_addr_nxt = r_clr_addr + 1'b1;
                end
            end
            S_READY: begin
                if (clear_i) begin
                    w_state_nxt    = S_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = S_CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    assign ready_o    = (r_state == S_READY);
    assign w_clr_we   = (r_state == S_CLEAR);
    // A clear request sampled in READY kills both new and in-flight writes that cycle.
    assign w_accept   = ready_o & ~clear_i;
    assign w_s2_we    = r_s2_valid & {WP{w_accept}};
    assign w_s2_wdata = r_s2_din ^ r_s2_other;
    assign w_racc     = ren_i & {RP{ready_o}};

    // Same-cycle collisions: a byte goes to the lowest-indexed port that enables it.
    always_comb begin
        w_wacc = wen_i & {WP{w_accept}};
        w_lost = '0;
        for (int p = 1; p < WP; p++) begin
            for (int q = 0; q < p; q++) begin
                if (w_wacc[p] && w_wacc[q] && (waddr_i[p] == waddr_i[q])) begin
                    w_lost[p] = w_lost[p] | (bwe_i[p] & bwe_i[q]);
                end
            end
        end
        w_eff_bwe = bwe_i & ~w_lost;
        for (int p = 0; p < WP; p++) begin
            w_conf[p] = |w_lost[p];
        end
    end

    // Bank storage. Every copy of a bank holds identical contents; copies exist only
    // to give each reader its own port. Stage-2 writes are forwarded per byte.
    for (genvar gb = 0; gb < WP; gb++) begin : g_bank
        assign w_wpart[gb][gb] = '0;

        for (genvar gc = 0; gc < NL; gc++) begin : g_lvt
            localparam int P = (gc < gb) ? gc : gc + 1;
            logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];

            always_ff @(posedge clk) begin
                if (w_clr_we) begin
                    r_mem[r_clr_addr] <= '0;
                end else if (w_s2_we[gb]) begin
                    for (int k = 0; k < NB; k++) begin
                        if (r_s2_bwe[gb][k]) begin
                            r_mem[r_s2_addr[gb]][8*k +: 8] <= w_s2_wdata[gb][8*k +: 8];
                        end
                    end
                end
            end

            assign w_wpart[P][gb] = f_merge(r_mem[waddr_i[P]],
                (w_s2_we[gb] && (r_s2_addr[gb] == waddr_i[P])) ? r_s2_bwe[gb] : '0,
                w_s2_wdata[gb]);
        end

        for (genvar gr = 0; gr < RP; gr++) begin : g_rd
            logic [MEM_WIDTH-1:0] r_mem [MEM_DEPTH];

            always_ff @(posedge clk) begin
                if (w_clr_we) begin
                    r_mem[r_clr_addr] <= '0;
                end else if (w_s2_we[gb]) begin
                    for (int k = 0; k < NB; k++) begin
                        if (r_s2_bwe[gb][k]) begin
                            r_mem[r_s2_addr[gb]][8*k +: 8] <= w_s2_wdata[gb][8*k +: 8];
                        end
                    end
                end
            end

            assign w_rpart[gr][gb] = f_merge(r_mem[raddr_i[gr]],
                (w_s2_we[gb] && (r_s2_addr[gb] == raddr_i[gr])) ? r_s2_bwe[gb] : '0,
                w_s2_wdata[gb]);
        end
    end

    always_comb begin
        w_other = '0;
        for (int p = 0; p < WP; p++) begin
            for (int q = 0; q < WP; q++) begin
                w_other[p] = w_other[p] ^ w_wpart[p][q];
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int r = 0; r < RP; r++) begin
            for (int b = 0; b < WP; b++) begin
                w_rdata[r] = w_rdata[r] ^ w_rpart[r][b];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s2_valid <= '0;
            r_s2_addr  <= '0;
            r_s2_bwe   <= '0;
            r_s2_din   <= '0;
            r_s2_other <= '0;
            r_conflict <= '0;
        end else begin
            r_s2_valid <= w_wacc;
            r_s2_addr  <= waddr_i;
            r_s2_bwe   <= w_eff_bwe;
            r_s2_din   <= din_i;
            r_s2_other <= w_other;
            r_conflict <= w_conf;
        end
    end

    assign conflict_o = r_conflict;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rv1 <= '0;
            r_rd1 <= '0;
        end else begin
            r_rv1 <= w_racc;
            for (int r = 0; r < RP; r++) begin
                if (w_racc[r]) begin
                    r_rd1[r] <= w_rdata[r];
                end
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [RP-1:0]                r_rv2;
        logic [RP-1:0][MEM_WIDTH-1:0] r_rd2;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_rv2 <= '0;
                r_rd2 <= '0;
            end else begin
                r_rv2 <= r_rv1;
                for (int r = 0; r < RP; r++) begin
                    if (r_rv1[r]) begin
                        r_rd2[r] <= r_rd1[r];
                    end
                end
            end
        end

        assign dvalid_o = r_rv2;
        assign dout_o   = r_rd2;
    end else begin : g_lat1
        assign dvalid_o = r_rv1;
        assign dout_o   = r_rd1;
    end

endmodule

// File: tb/tb_vrf_mp_xor.sv
// Directed bench for vrf_mp_xor: reads push expected words into a scoreboard queue,
// a monitor pops and compares whenever dvalid_o is seen.
module tb_vrf_mp_xor;

    localparam int R  = 8;
    localparam int W  = 4;
    localparam int D  = 32;
    localparam int MW = 32;
    localparam int AW = 5;
    localparam int NB = 4;

    logic                    clk = 1'b0;
    logic                    rstn;
    logic                    clear_i;
    logic                    ready_o;
    logic [R-1:0][AW-1:0]    raddr_i;
    logic [R-1:0]            ren_i;
    logic [R-1:0][MW-1:0]    dout_o;
    logic [R-1:0]            dvalid_o;
    logic [W-1:0][AW-1:0]    waddr_i;
    logic [W-1:0][NB-1:0]    bwe_i;
    logic [W-1:0]            wen_i;
    logic [W-1:0][MW-1:0]    din_i;
    logic [W-1:0]            conflict_o;

    vrf_mp_xor #(
        .R_PORTS_NUM (R),
        .W_PORTS_NUM (W),
        .MEM_DEPTH   (D),
        .MEM_WIDTH   (MW),
        .READ_LATENCY(1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear_i   (clear_i),
        .ready_o   (ready_o),
        .raddr_i   (raddr_i),
        .ren_i     (ren_i),
        .dout_o    (dout_o),
        .dvalid_o  (dvalid_o),
        .waddr_i   (waddr_i),
        .bwe_i     (bwe_i),
        .wen_i     (wen_i),
        .din_i     (din_i),
        .conflict_o(conflict_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           port;
        logic [MW-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wen_i   = '0;
        ren_i   = '0;
        clear_i = 1'b0;
        bwe_i   = '0;
        din_i   = '0;
        waddr_i = '0;
        raddr_i = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        idle();
    endtask

    task automatic wr(input int p, input int a, input logic [NB-1:0] be, input logic [MW-1:0] d);
        wen_i[p]   = 1'b1;
        waddr_i[p] = AW'(a);
        bwe_i[p]   = be;
        din_i[p]   = d;
    endtask

    task automatic rd(input int p, input int a, input logic [MW-1:0] d);
        ren_i[p]   = 1'b1;
        raddr_i[p] = AW'(a);
        sb_q.push_back('{port: p, data: d});
    endtask

    // Counts clock edges until ready_o is seen high; optionally re-pulses clear_i.
    task automatic wait_ready(input int restart_at, output int n);
        n = 0;
        while (ready_o !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                check("no_dvalid_in_clear", dvalid_o, 0);
                ren_i = '0;
            end
            clear_i = (restart_at > 0 && n == restart_at);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int p = 0; p < R; p++) begin
            if (dvalid_o[p] === 1'b1) begin
                n_vec++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_read port %0d: got 0x%08h want no response", p, dout_o[p]);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.port != p || dout_o[p] !== mon_e.data) begin
                        n_err++;
                        $display("FAIL read_port%0d: got 0x%08h want 0x%08h on port %0d",
                                 p, dout_o[p], mon_e.data, mon_e.port);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        check("rst_ready", ready_o, 0);
        check("rst_dvalid", dvalid_o, 0);
        check("rst_conflict", conflict_o, 0);
        check("rst_dout0", dout_o[0], 0);
        check("rst_dout7", dout_o[7], 0);

        // reset mid-sweep restarts the sweep
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        check("ready_mid_sweep", ready_o, 0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        wait_ready(0, n_cyc);
        check("reset_sweep_cycles", n_cyc, 32);
        @(negedge clk);
        idle();

        // fresh array reads zero everywhere
        rd(0, 0, 0); rd(1, 5, 0); rd(2, 9, 0); rd(3, 31, 0);
        rd(4, 4, 0); rd(5, 3, 0); rd(6, 6, 0); rd(7, 17, 0);
        tick();
        tick();

        // write then read next cycle, data from stage-2 bypass
        wr(2, 5, 4'hF, 32'hDEADBEEF);
        tick();
        rd(7, 5, 32'hDEADBEEF);
        tick();
        check("dvalid_latency", dvalid_o, 8'h80);
        tick();
        check("dvalid_drop", dvalid_o, 0);
        check("dout_hold", dout_o[7], 32'hDEADBEEF);

        // same-cycle collision, lowest port wins
        wr(0, 9, 4'hF, 32'h11111111);
        wr(3, 9, 4'h3, 32'h22222222);
        tick();
        check("conflict_loser", conflict_o, 4'b1000);
        tick();
        check("conflict_pulse_end", conflict_o, 0);
        rd(0, 9, 32'h11111111);
        tick();

        // disjoint bytes, same address: both land, no conflict
        wr(1, 10, 4'hC, 32'h12345678);
        wr(2, 10, 4'h3, 32'h9ABCDEF0);
        tick();
        check("conflict_disjoint", conflict_o, 0);
        rd(1, 10, 32'h1234DEF0);
        tick();
        tick();

        // byte write; same-cycle read sees old value
        wr(0, 4, 4'hF, 32'hAABBCCDD);
        tick();
        tick();
        wr(1, 4, 4'h1, 32'h00000055);
        rd(0, 4, 32'hAABBCCDD);
        tick();
        rd(1, 4, 32'hAABBCC55);
        tick();
        tick();

        // back-to-back writes from different ports
        wr(0, 3, 4'hF, 32'h00000001);
        tick();
        wr(1, 3, 4'hF, 32'h00000002);
        rd(2, 3, 32'h00000001);
        tick();
        rd(3, 3, 32'h00000002);
        tick();
        tick();

        // all write ports and all read ports at once
        wr(0, 20, 4'hF, 32'hA0A0A0A0);
        wr(1, 21, 4'hF, 32'hB1B1B1B1);
        wr(2, 22, 4'hF, 32'hC2C2C2C2);
        wr(3, 23, 4'hF, 32'hD3D3D3D3);
        tick();
        tick();
        rd(0, 20, 32'hA0A0A0A0); rd(1, 21, 32'hB1B1B1B1);
        rd(2, 22, 32'hC2C2C2C2); rd(3, 23, 32'hD3D3D3D3);
        rd(4, 23, 32'hD3D3D3D3); rd(5, 22, 32'hC2C2C2C2);
        rd(6, 21, 32'hB1B1B1B1); rd(7, 20, 32'hA0A0A0A0);
        tick();
        tick();

        // clear pulse with simultaneous write; earlier read still completes
        wr(2, 6, 4'hF, 32'h66666666);
        tick();
        tick();
        rd(3, 6, 32'h66666666);
        tick();
        wr(1, 11, 4'hF, 32'h00000013);
        tick();
        clear_i = 1'b1;
        wr(0, 6, 4'hF, 32'h00000007);
        rd(0, 4, 32'hAABBCC55);
        @(posedge clk);
        #1;
        idle();
        ren_i = '1;
        check("ready_drop", ready_o, 0);
        wait_ready(0, n_cyc);
        check("clear_sweep_cycles", n_cyc, 32);
        @(negedge clk);
        idle();
        rd(0, 6, 0); rd(1, 5, 0); rd(2, 11, 0); rd(3, 4, 0);
        tick();
        tick();

        // clear_i during CLEAR restarts the sweep
        clear_i = 1'b1;
        @(posedge clk);
        #1;
        clear_i = 1'b0;
        wait_ready(9, n_cyc);
        check("clear_restart_cycles", n_cyc, 42);
        @(negedge clk);
        idle();
        repeat (3) tick();

        check("scoreboard_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
